// File: rtl/cache_arb_pkg.sv
// Shared types and default parameters for the cache SRAM arbiter and the
// round-robin helper it shares with the HyperRAM command path.
package cache_arb_pkg;

  typedef enum logic [1:0] {
    OPEN  = 2'd0,
    LOCK0 = 2'd1,
    LOCK1 = 2'd2
  } arb_state_t;

  typedef logic port_id_t;

  localparam int DEF_ADDR_W         = 14;
  localparam int DEF_DATA_W         = 32;
  localparam int DEF_LOCK_TIMEOUT   = 16;
  localparam int DEF_MAX_LOCK_BEATS = 64;

  // Width that holds max(a, b) with headroom so saturation never wraps.
  function automatic int cnt_width(input int a, input int b);
    return $clog2((a > b) ? a : b) + 1;
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-requester round-robin grant. The port not granted last wins a contest;
// the history only moves when the caller confirms the beat with i_advance.
module rr_arb2
  import cache_arb_pkg::*;
#(
  parameter port_id_t RESET_LAST = 1'b1
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic [1:0] i_req,
  input  logic       i_advance,
  output logic [1:0] o_grant
);

  port_id_t r_last_grant;

  always_comb begin
    // NOTE: give every always_comb output a value before any branch so no
    // path can leave it unassigned and infer a latch.
    o_grant = i_req;
    if (i_req == 2'b11) o_grant = r_last_grant ? 2'b01 : 2'b10;
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // flop samples pre-edge values regardless of block ordering.
  always_ff @(posedge i_clk) begin
    if (i_rst)                        r_last_grant <= RESET_LAST;
    else if (i_advance && |o_grant)   r_last_grant <= o_grant[1];
  end

endmodule

// File: rtl/cache_mem_arbiter.sv
// Shares the single-port cache SRAM between the CPU lookup (port 0) and the
// HyperRAM refill engine (port 1) with round-robin grant and a bounded lock.
module cache_mem_arbiter
  import cache_arb_pkg::*;
#(
  parameter int ADDR_W         = DEF_ADDR_W,
  parameter int DATA_W         = DEF_DATA_W,
  parameter int LOCK_TIMEOUT   = DEF_LOCK_TIMEOUT,
  parameter int MAX_LOCK_BEATS = DEF_MAX_LOCK_BEATS
) (
  input  logic                  sys_clk,
  input  logic                  sys_rst,
  input  logic                  p0_req_valid,
  output logic                  p0_req_ready,
  input  logic [ADDR_W-1:0]     p0_req_addr,
  input  logic                  p0_req_we,
  input  logic [DATA_W/8-1:0]   p0_req_sel,
  input  logic [DATA_W-1:0]     p0_req_wdata,
  input  logic                  p0_req_lock,
  output logic                  p0_rsp_valid,
  output logic [DATA_W-1:0]     p0_rsp_rdata,
  input  logic                  p1_req_valid,
  output logic                  p1_req_ready,
  input  logic [ADDR_W-1:0]     p1_req_addr,
  input  logic                  p1_req_we,
  input  logic [DATA_W/8-1:0]   p1_req_sel,
  input  logic [DATA_W-1:0]     p1_req_wdata,
  input  logic                  p1_req_lock,
  output logic                  p1_rsp_valid,
  output logic [DATA_W-1:0]     p1_rsp_rdata,
  output logic [ADDR_W-1:0]     mem_addr,
  output logic [DATA_W-1:0]     mem_wdata,
  output logic                  mem_we,
  output logic [DATA_W/8-1:0]   mem_we_sel,
  input  logic [DATA_W-1:0]     mem_rdata
);

  localparam int SEL_W = DATA_W / 8;
  localparam int CNT_W = cnt_width(LOCK_TIMEOUT, MAX_LOCK_BEATS);
  localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(LOCK_TIMEOUT);
  localparam logic [CNT_W-1:0] MAXBEAT_C = CNT_W'(MAX_LOCK_BEATS);

  arb_state_t         r_state;
  logic [CNT_W-1:0]   r_beats;
  logic [CNT_W-1:0]   r_idle;
  logic               r_rsp_pending;
  port_id_t           r_rsp_port;
  logic               r_rsp_we;
  logic [ADDR_W-1:0]  r_mem_addr;
  logic [DATA_W-1:0]  r_mem_wdata;

  logic [1:0]         w_req;
  logic [1:0]         w_grant;
  logic               w_accept;
  port_id_t           w_gport;
  logic               w_lock;
  logic               w_we;
  logic [ADDR_W-1:0]  w_addr;
  logic [DATA_W-1:0]  w_wdata;
  logic [SEL_W-1:0]   w_sel;
  logic [CNT_W-1:0]   w_beats_inc;
  logic [CNT_W-1:0]   w_idle_inc;
  logic               w_rsp_v0;
  logic               w_rsp_v1;

  // A lock hides the other port from the round-robin entirely.
  always_comb begin
    w_req = 2'b00;
    if (!sys_rst) begin
      unique case (r_state)
        OPEN:    w_req = {p1_req_valid, p0_req_valid};
        LOCK0:   w_req = {1'b0, p0_req_valid};
        LOCK1:   w_req = {p1_req_valid, 1'b0};
        default: w_req = 2'b00;
      endcase
    end
  end

  rr_arb2 #(.RESET_LAST(1'b1)) u_rr (
    .i_clk     (sys_clk),
    .i_rst     (sys_rst),
    .i_req     (w_req),
    .i_advance (1'b1),
    .o_grant   (w_grant)
  );

  assign w_accept = |w_grant;
  assign w_gport  = w_grant[1];
  assign w_lock   = w_gport ? p1_req_lock  : p0_req_lock;
  assign w_we     = w_gport ? p1_req_we    : p0_req_we;
  assign w_addr   = w_gport ? p1_req_addr  : p0_req_addr;
  assign w_wdata  = w_gport ? p1_req_wdata : p0_req_wdata;
  assign w_sel    = w_gport ? p1_req_sel   : p0_req_sel;

  assign p0_req_ready = w_grant[0];
  assign p1_req_ready = w_grant[1];

  // Idle cycles keep the last driven address so the SRAM sees a stable read.
  assign mem_addr   = w_accept ? w_addr  : r_mem_addr;
  assign mem_wdata  = w_accept ? w_wdata : r_mem_wdata;
  assign mem_we     = w_accept & w_we;
  assign mem_we_sel = w_accept ? w_sel : '0;

  assign w_beats_inc = (&r_beats) ? r_beats : r_beats + 1'b1;
  assign w_idle_inc  = (&r_idle)  ? r_idle  : r_idle  + 1'b1;

  assign w_rsp_v0     = !sys_rst && r_rsp_pending && (r_rsp_port == 1'b0);
  assign w_rsp_v1     = !sys_rst && r_rsp_pending && (r_rsp_port == 1'b1);
  assign p0_rsp_valid = w_rsp_v0;
  assign p1_rsp_valid = w_rsp_v1;
  assign p0_rsp_rdata = (w_rsp_v0 && !r_rsp_we) ? mem_rdata : '0;
  assign p1_rsp_rdata = (w_rsp_v1 && !r_rsp_we) ? mem_rdata : '0;

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      r_state       <= OPEN;
      r_beats       <= '0;
      r_idle        <= '0;
      r_rsp_pending <= 1'b0;
      r_rsp_port    <= 1'b0;
      r_rsp_we      <= 1'b0;
      r_mem_addr    <= '0;
      r_mem_wdata   <= '0;
    end else begin
      r_rsp_pending <= w_accept;
      if (w_accept) begin
        r_rsp_port  <= w_gport;
        r_rsp_we    <= w_we;
        r_mem_addr  <= w_addr;
        r_mem_wdata <= w_wdata;
      end

      unique case (r_state)
        OPEN: begin
          if (w_accept && w_lock) begin
            r_beats <= CNT_W'(1);
            r_idle  <= '0;
            if (MAX_LOCK_BEATS > 1) r_state <= w_gport ? LOCK1 : LOCK0;
          end
        end
        LOCK0, LOCK1: begin
          // The beat that hits the limit is served; ownership drops after it.
          if (w_accept) begin
            r_beats <= w_beats_inc;
            r_idle  <= '0;
            if (!w_lock || w_beats_inc >= MAXBEAT_C) r_state <= OPEN;
          end else begin
            r_idle <= w_idle_inc;
            if (w_idle_inc >= TIMEOUT_C) r_state <= OPEN;
          end
        end
        default: r_state <= OPEN;
      endcase
    end
  end

endmodule

// File: doc/cache_mem_arbiter.md
# cache_mem_arbiter

Shares the single-port 16K-word cache SRAM (DFFRAM, 14-bit word address, 32-bit data, per-byte write enables, 1-cycle synchronous read) between two requesters: port 0, the CPU-side cache lookup, and port 1, the HyperRAM refill/writeback engine. It arbitrates per cycle with round-robin fairness and supports a bounded bus lock so that refill bursts run uninterrupted. It returns a 1-cycle-latency response to the granted port. It sits between the SoC cache logic and the DFFRAM instance in the top level.

## Interface
- ADDR_W, 14, word address width
- DATA_W, 32, data width; byte-select width is DATA_W/8
- LOCK_TIMEOUT, 16, idle cycles after which a held lock is dropped
- MAX_LOCK_BEATS, 64, accepted beats after which a held lock is forcibly released
- sys_clk  in  1  system clock; the only clock
- sys_rst  in  1  synchronous, active-high reset
- pN_req_valid  in  1  request from port N (N = 0, 1)
- pN_req_ready  out  1  request accepted this cycle (combinational)
- pN_req_addr  in  ADDR_W  word address
- pN_req_we  in  1  1 = write, 0 = read
- pN_req_sel  in  DATA_W/8  byte enables for writes
- pN_req_wdata  in  DATA_W  write data
- pN_req_lock  in  1  keep ownership after this beat
- pN_rsp_valid  out  1  response for the beat accepted in the previous cycle
- pN_rsp_rdata  out  DATA_W  read data; 0 for write responses
- mem_addr  out  ADDR_W  to the SRAM A input
- mem_wdata  out  DATA_W  to the SRAM Di input
- mem_we  out  1  write strobe
- mem_we_sel  out  DATA_W/8  byte enables; the top level ANDs these with mem_we
- mem_rdata  in  DATA_W  from the SRAM Do output

## Operation
- Grant
  - In state OPEN, a single valid port is granted.
  - If both ports are valid, the port not granted last wins. `last_grant` updates only on an accepted beat.
- Memory drive
  - A granted request is `pN_req_ready` = 1 in the same cycle it is presented.
  - In that cycle the granted port's addr, wdata, and sel drive `mem_*`, and `mem_we` = `pN_req_we`.
  - With no grant, `mem_we` = 0 and `mem_addr`/`mem_wdata` hold their previous values; the SRAM is always enabled, so the resulting read is harmless.
- Response
  - A registered `rsp_port` and `rsp_pending` track the beat accepted in cycle T.
  - In cycle T+1 that port gets `rsp_valid` = 1. `rsp_rdata` = `mem_rdata` for reads and 0 for writes.
  - The other port's `rsp_rdata` is 0.
  - Requesters must always accept responses; there is no response backpressure.
- States: OPEN, LOCK0, LOCK1.
  - OPEN → LOCKn: port n is granted a beat with `pN_req_lock` = 1. The beat counter loads 1 and the idle counter clears.
  - LOCKn: only port n is granted. The other port sees `req_ready` = 0 even if valid.
  - Each accepted beat increments the beat counter and clears the idle counter. Each cycle without a valid owner request increments the idle counter.
  - LOCKn → OPEN happens on whichever comes first:
    - an owner beat accepted with `req_lock` = 0; that beat itself is still served;
    - the idle counter reaching LOCK_TIMEOUT;
    - the beat counter reaching MAX_LOCK_BEATS; the beat that reaches the limit is served and ownership drops afterward.
  - On release, `last_grant` = n, so a waiting other port wins the next contested cycle.
- A forced release does not signal the owner. The owner's subsequent `req_lock` beats re-enter arbitration normally.

## Timing
- Reset, synchronous:
  - state = OPEN, `last_grant` = 1 (port 0 wins the first contest);
  - counters = 0, `rsp_pending` = 0;
  - `mem_addr` = 0, `mem_wdata` = 0;
  - while `sys_rst` is high, all `req_ready`, `rsp_valid`, and `mem_we` are 0.
- Reset mid-lock or with a response pending: the lock is dropped and the pending response is discarded; no `rsp_valid` is issued after reset.
- Throughput is 1 beat/cycle sustained with back-to-back grants. Read latency is exactly 1 cycle from acceptance to `rsp_valid`.
- Same-address write then read on consecutive beats returns the new data; this relies on SRAM write-before-read ordering across cycles.
- Counter width is $clog2(max(LOCK_TIMEOUT, MAX_LOCK_BEATS)) + 1. Counters saturate and never wrap.
- Simultaneous `req_lock` from both ports in OPEN: the round-robin winner takes the lock; the loser waits.

## Structure
- Package `cache_arb_pkg`:
  - `arb_state_t` enum {OPEN, LOCK0, LOCK1}
  - `port_id_t` (1 bit)
  - default parameter constants
- Sub-module `rr_arb2`: two-request round-robin grant with a `last_grant` register and an `advance` strobe. This sub-module is reused by the HyperRAM command path.
- Lock FSM, counters, and response tracking live in `cache_mem_arbiter`. Target size is 150–250 lines.

## Test plan
- Reset then port 0 read of addr 0x0010 with the SRAM preloaded to 0xDEADBEEF → `p0_req_ready` in the same cycle; `p0_rsp_valid` with 0xDEADBEEF the next cycle; `p1_rsp_valid` stays 0.
- Both ports valid continuously, no lock → grants alternate 0,1,0,1…, starting with port 0 after reset.
- Port 1 issues 8 beats with `req_lock` = 1 and the last beat with lock = 0; port 0 valid throughout → port 0 is stalled for 8 cycles and granted in cycle 9.
- Port 1 locks, then drops `req_valid` for 16 cycles → release on the 16th idle cycle; a waiting port 0 is granted the next cycle.
- Port 1 holds lock for 70 beats with port 0 waiting → port 0 is granted exactly after beat 64.
- Write 0x12345678 with sel = 4'b0011 over 0xFFFFFFFF, then read the same address → write `rsp_rdata` = 0; read returns 0xFFFF5678.
